// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing parameter sets, pattern mode codes and the colour-bar palette.
package vga_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33
  };

  localparam vga_timing_t SVGA_800x600_60 = '{
    h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23
  };

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_GRID    = 2'd2,
    MODE_SOLID   = 2'd3
  } pat_mode_e;

  // Returns {r,g,b} on/off for bar 0..7, left to right.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video output bus of the pattern generator: syncs, data-enable, colour channels and pixel coordinates.
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 4,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               frame_start;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;

  modport master (output hsync, vsync, de, frame_start, r, g, b, x, y);
  modport slave  (input  hsync, vsync, de, frame_start, r, g, b, x, y);
endinterface

// File: rtl/vga_timing_core.sv
// Horizontal/vertical pixel counters with combinational sync, active and frame-wrap decode.
// Counters advance only on pix_en_i; decode outputs describe the current counter value.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int Y_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en_i,
  output logic [X_W-1:0] h_cnt_o,
  output logic [Y_W-1:0] v_cnt_o,
  output logic           active_o,
  output logic           hs_act_o,
  output logic           vs_act_o,
  output logic           frame_wrap_o,
  output logic           frame_first_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEGIN = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEGIN = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;
  logic           h_last, v_last;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_i) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign active_o      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_act_o      = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
  assign vs_act_o      = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
  assign frame_wrap_o  = h_last && v_last;
  assign frame_first_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with built-in test patterns; every output is registered one pix_en cycle after its counter value.
// No backpressure: pix_en_i is the only throttle and all state holds while it is low.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = int'(VGA_640x480_60.h_active),
  parameter int H_FP     = int'(VGA_640x480_60.h_fp),
  parameter int H_SYNC   = int'(VGA_640x480_60.h_sync),
  parameter int H_BP     = int'(VGA_640x480_60.h_bp),
  parameter int V_ACTIVE = int'(VGA_640x480_60.v_active),
  parameter int V_FP     = int'(VGA_640x480_60.v_fp),
  parameter int V_SYNC   = int'(VGA_640x480_60.v_sync),
  parameter int V_BP     = int'(VGA_640x480_60.v_bp),
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en_i,
  input  logic [1:0]           mode_i,
  input  logic [3*COLOR_W-1:0] solid_rgb_i,
  vga_pattern_gen_if.master    vga_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [X_W-1:0] X_ACT_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_ACT_LAST = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           active, hs_act, vs_act, frame_wrap, frame_first;

  vga_timing_core #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .pix_en_i      (pix_en_i),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .active_o      (active),
    .hs_act_o      (hs_act),
    .vs_act_o      (vs_act),
    .frame_wrap_o  (frame_wrap),
    .frame_first_o (frame_first)
  );

  pat_mode_e            mode_q;
  logic [3*COLOR_W-1:0] solid_q;
  logic [3*COLOR_W-1:0] rgb_d, rgb_q;
  logic [2:0]           bar_idx, bar_c;
  logic                 grid_on;
  logic                 hsync_q, vsync_q, de_q, frame_start_q;
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;

  // Pixels past 8*BAR_W stay in the last (black) bar rather than wrapping.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= X_W'(i * BAR_W)) bar_idx = 3'(i);
    end
    bar_c   = bar_rgb(bar_idx);
    grid_on = (h_cnt[5:0] == 6'd0) || (v_cnt[5:0] == 6'd0) ||
              (h_cnt == X_ACT_LAST) || (v_cnt == Y_ACT_LAST);
    rgb_d   = '0;
    case (mode_q)
      MODE_BARS:    rgb_d = {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}};
      MODE_CHECKER: rgb_d = {(3*COLOR_W){~(h_cnt[5] ^ v_cnt[5])}};
      MODE_GRID:    rgb_d = {(3*COLOR_W){grid_on}};
      default:      rgb_d = solid_q;
    endcase
    if (!active) rgb_d = '0;
  end

  // Pattern selection only changes on the last pixel of a frame so no frame mixes patterns.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      mode_q        <= MODE_BARS;
      solid_q       <= '0;
    end else begin
      frame_start_q <= pix_en_i && frame_first;
      if (pix_en_i) begin
        hsync_q <= hs_act ? HS_POL : ~HS_POL;
        vsync_q <= vs_act ? VS_POL : ~VS_POL;
        de_q    <= active;
        rgb_q   <= rgb_d;
        x_q     <= h_cnt;
        y_q     <= v_cnt;
        if (frame_wrap) begin
          mode_q  <= pat_mode_e'(mode_i);
          solid_q <= solid_rgb_i;
        end
      end
    end
  end

  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.de          = de_q;
  assign vga_o.frame_start = frame_start_q;
  assign vga_o.r           = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vga_o.g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_o.b           = rgb_q[COLOR_W-1:0];
  assign vga_o.x           = x_q;
  assign vga_o.y           = y_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench on a reduced 164x40 raster (H_TOTAL 200, V_TOTAL 50) plus an inverted-polarity 1-bit-colour build.
module tb_vga_pattern_gen;

  localparam int HT    = 200;
  localparam int FRAME = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [1:0]  mode;
  logic [11:0] solid;
  logic [2:0]  solid1;

  vga_pattern_gen_if #(.COLOR_W(4), .X_W(8), .Y_W(6)) vif ();
  vga_pattern_gen_if #(.COLOR_W(1), .X_W(8), .Y_W(6)) vif1 ();

  vga_pattern_gen #(
    .H_ACTIVE(164), .H_FP(8), .H_SYNC(12), .H_BP(16),
    .V_ACTIVE(40),  .V_FP(2), .V_SYNC(3),  .V_BP(5),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .pix_en_i(pix_en), .mode_i(mode), .solid_rgb_i(solid), .vga_o(vif)
  );

  vga_pattern_gen #(
    .H_ACTIVE(164), .H_FP(8), .H_SYNC(12), .H_BP(16),
    .V_ACTIVE(40),  .V_FP(2), .V_SYNC(3),  .V_BP(5),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(1)
  ) dut1 (
    .clk(clk), .rst(rst), .pix_en_i(pix_en), .mode_i(mode), .solid_rgb_i(solid1), .vga_o(vif1)
  );

  always #5 clk = ~clk;

  logic [11:0] rgb0;
  logic [2:0]  rgb1;
  assign rgb0 = {vif.r, vif.g, vif.b};
  assign rgb1 = {vif1.r, vif1.g, vif1.b};

  int n_cmp = 0;
  int n_err = 0;
  int hs_low, vs_low, de_cnt, blank_rgb, fs_cnt, hold_bad, seq_bad, hs_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hsync"}, 32'(vif.hsync), 32'h1);
    chk({tag, "_vsync"}, 32'(vif.vsync), 32'h1);
    chk({tag, "_de"},    32'(vif.de), 32'h0);
    chk({tag, "_rgb"},   32'(rgb0), 32'h0);
    chk({tag, "_x"},     32'(vif.x), 32'h0);
    chk({tag, "_y"},     32'(vif.y), 32'h0);
    chk({tag, "_fs"},    32'(vif.frame_start), 32'h0);
    chk({tag, "_hsync1"}, 32'(vif1.hsync), 32'h0);
    chk({tag, "_vsync1"}, 32'(vif1.vsync), 32'h0);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b1; mode = 2'd0; solid = 12'h000; solid1 = 3'b101;
    hs_low = 0; vs_low = 0; de_cnt = 0; blank_rgb = 0; fs_cnt = 0;
    repeat (5) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // Four full frames at full rate: bars, solid, checker, grid.
    for (int p = 0; p <= 4 * FRAME; p++) begin
      @(negedge clk);
      if (p < HT && vif.hsync === 1'b0) hs_low++;
      if (p < FRAME) begin
        if (vif.vsync === 1'b0) vs_low++;
        if (vif.de === 1'b1) de_cnt++;
        if (vif.de !== 1'b1 && rgb0 !== 12'h000) blank_rgb++;
      end
      if (p > 0 && p <= FRAME && vif.frame_start === 1'b1) fs_cnt++;
      case (p)
        0: begin
          chk("p0_fs", 32'(vif.frame_start), 32'h1);
          chk("p0_x", 32'(vif.x), 32'h0);
          chk("p0_y", 32'(vif.y), 32'h0);
          chk("p0_de", 32'(vif.de), 32'h1);
          chk("bar_white_x0", 32'(rgb0), 32'hFFF);
          chk("bar1_white_x0", 32'(rgb1), 32'h7);
        end
        1:    chk("p1_fs", 32'(vif.frame_start), 32'h0);
        19:   chk("bar_white_x19", 32'(rgb0), 32'hFFF);
        20: begin
          chk("bar_yellow_x20", 32'(rgb0), 32'hFF0);
          chk("bar1_yellow_x20", 32'(rgb1), 32'h6);
        end
        40:   chk("bar_cyan_x40", 32'(rgb0), 32'h0FF);
        60:   chk("bar_green_x60", 32'(rgb0), 32'h0F0);
        80:   chk("bar_magenta_x80", 32'(rgb0), 32'hF0F);
        100:  chk("bar_red_x100", 32'(rgb0), 32'hF00);
        120:  chk("bar_blue_x120", 32'(rgb0), 32'h00F);
        163: begin
          chk("bar_rem_x163_de", 32'(vif.de), 32'h1);
          chk("bar_rem_x163_rgb", 32'(rgb0), 32'h000);
        end
        164: begin
          chk("blank_x164_de", 32'(vif.de), 32'h0);
          chk("blank_x164_rgb", 32'(rgb0), 32'h000);
        end
        171:  chk("hs_before", 32'(vif.hsync), 32'h1);
        172: begin
          chk("hs_first", 32'(vif.hsync), 32'h0);
          chk("hs1_first", 32'(vif1.hsync), 32'h1);
        end
        183:  chk("hs_last", 32'(vif.hsync), 32'h0);
        184:  chk("hs_after", 32'(vif.hsync), 32'h1);
        199:  chk("x199", 32'(vif.x), 32'd199);
        200: begin
          chk("line1_x", 32'(vif.x), 32'h0);
          chk("line1_y", 32'(vif.y), 32'h1);
        end
        5000: begin mode = 2'd3; solid = 12'hA5C; end
        5200: chk("midframe_still_bars", 32'(rgb0), 32'hFFF);
        7820: chk("midframe_bars_y39", 32'(rgb0), 32'hFF0);
        8399: chk("vs_before", 32'(vif.vsync), 32'h1);
        8400: begin
          chk("vs_first", 32'(vif.vsync), 32'h0);
          chk("vs1_first", 32'(vif1.vsync), 32'h1);
        end
        8999: chk("vs_last", 32'(vif.vsync), 32'h0);
        9000: chk("vs_after", 32'(vif.vsync), 32'h1);
        10000: begin
          chk("f1_fs", 32'(vif.frame_start), 32'h1);
          chk("f1_x", 32'(vif.x), 32'h0);
          chk("f1_y", 32'(vif.y), 32'h0);
          chk("solid_00", 32'(rgb0), 32'hA5C);
          chk("solid1_00", 32'(rgb1), 32'h5);
        end
        11170: chk("solid_blank", 32'(rgb0), 32'h000);
        15000: mode = 2'd1;
        16100: chk("solid_100_30", 32'(rgb0), 32'hA5C);
        20000: chk("chk_0_0", 32'(rgb0), 32'hFFF);
        20032: chk("chk_32_0", 32'(rgb0), 32'h000);
        22163: chk("chk_163_10", 32'(rgb0), 32'h000);
        25000: mode = 2'd2;
        26400: chk("chk_0_32", 32'(rgb0), 32'h000);
        26432: chk("chk_32_32", 32'(rgb0), 32'hFFF);
        27900: chk("chk_100_39", 32'(rgb0), 32'hFFF);
        30007: chk("grid_7_0", 32'(rgb0), 32'hFFF);
        31000: chk("grid_0_5", 32'(rgb0), 32'hFFF);
        31005: chk("grid_5_5", 32'(rgb0), 32'h000);
        31463: chk("grid_63_7", 32'(rgb0), 32'h000);
        31464: chk("grid_64_7", 32'(rgb0), 32'hFFF);
        31563: chk("grid_163_7", 32'(rgb0), 32'hFFF);
        34100: chk("grid_100_20", 32'(rgb0), 32'h000);
        34128: chk("grid_128_20", 32'(rgb0), 32'hFFF);
        37807: chk("grid_7_39", 32'(rgb0), 32'hFFF);
        default: ;
      endcase
    end
    chk("hs_low_clks", 32'(hs_low), 32'd12);
    chk("vs_low_clks", 32'(vs_low), 32'd600);
    chk("de_clks", 32'(de_cnt), 32'd6560);
    chk("blank_rgb_nonzero", 32'(blank_rgb), 32'd0);
    chk("fs_per_frame", 32'(fs_cnt), 32'd1);

    // Reset mid-frame at line 20 of frame 4.
    repeat (4000) @(negedge clk);
    chk("pre_rst_y", 32'(vif.y), 32'd20);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fs", 32'(vif.frame_start), 32'h1);
    chk("post_rst_x", 32'(vif.x), 32'h0);
    chk("post_rst_y", 32'(vif.y), 32'h0);
    chk("post_rst_de", 32'(vif.de), 32'h1);
    chk("post_rst_bars", 32'(rgb0), 32'hFFF);

    // Half-rate pixel enable over one full line.
    hold_bad = 0; seq_bad = 0; hs_clk = 0;
    for (int i = 1; i <= HT; i++) begin
      pix_en = 1'b0;
      @(negedge clk);
      if (vif.x !== 8'(i - 1) || vif.frame_start !== 1'b0) hold_bad++;
      if (vif.hsync === 1'b0) hs_clk++;
      pix_en = 1'b1;
      @(negedge clk);
      if (vif.hsync === 1'b0) hs_clk++;
      if (i < HT && vif.hsync !== ((i >= 172 && i < 184) ? 1'b0 : 1'b1)) seq_bad++;
      if (i == 20) chk("half_bar_yellow", 32'(rgb0), 32'hFF0);
    end
    chk("half_hold", 32'(hold_bad), 32'd0);
    chk("half_hs_seq", 32'(seq_bad), 32'd0);
    chk("half_hs_clks", 32'(hs_clk), 32'd24);
    chk("half_line_x", 32'(vif.x), 32'h0);
    chk("half_line_y", 32'(vif.y), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
